// File: rtl/roe_fetch.sv
// roe_fetch -- instruction fetch stage of the R.O.E core.
// Owns the program counter, drives the synchronous instruction memory address
// with the combinational next PC, and hands each 9-bit instruction plus a valid
// flag to the control decoder. Taken branches redirect through a loadable
// 16-entry target LUT with no bubble; a HALT word or running past the last
// memory word ends the program (the latter also raises err).
// Optional feature: define FETCH_PERF_EN to add the 16-bit saturating
// retired_cnt output.
module roe_fetch #(
  parameter int         PC_W       = 10,
  parameter int         IMEM_DEPTH = 1024,
  parameter logic [8:0] HALT_INSTR = 9'h1FF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [PC_W-1:0] start_pc,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic            lut_we,
  input  logic [3:0]      lut_waddr,
  input  logic [PC_W-1:0] lut_wdata,
  output logic [PC_W-1:0] imem_addr,
  input  logic [8:0]      imem_data,
  output logic [8:0]      instr,
  output logic            instr_valid,
  output logic [PC_W-1:0] pc,
  output logic            done,
  output logic            err
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]     retired_cnt
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [PC_W-1:0] LAST_PC = PC_W'(IMEM_DEPTH - 1);

  logic [1:0]      state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic            done_nxt, err_nxt;
  logic [PC_W-1:0] lut [16];
  logic            is_halt;
  logic            at_last;
  logic            start_ok;

  // The memory returns the word for the PC registered last cycle, so while
  // running imem_data is the instruction at pc.
  assign instr_valid = (state == S_RUN);
  assign instr       = instr_valid ? imem_data : '0;
  assign is_halt     = (imem_data == HALT_INSTR);
  assign at_last     = (pc == LAST_PC);
  assign start_ok    = start && (state != S_RUN);

  // Next-state / next-PC selection; stall outranks halt, which outranks branch.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nxt = state;
    pc_nxt    = pc;
    done_nxt  = done;
    err_nxt   = err;
    if (state == S_RUN) begin
      if (!stall) begin
        if (is_halt) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
        end else if (branch_taken) begin
          // LUT read sees the registered array, so a same-cycle write is not visible.
          pc_nxt = lut[imem_data[3:0]];
        end else if (at_last) begin
          // Sequential advance past the last word ends the program; no wrap.
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
          err_nxt   = 1'b1;
        end else begin
          pc_nxt = pc + PC_W'(1);
        end
      end
    end else if (start_ok) begin
      state_nxt = S_RUN;
      pc_nxt    = start_pc;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
    end
  end

  // Memory address: next PC, except IDLE always presents start_pc (so the first
  // word is ready one cycle after start) and reset forces zero.
  always_comb begin
    if (!rst_n)              imem_addr = '0;
    else if (state == S_IDLE) imem_addr = start_pc;
    else                     imem_addr = pc_nxt;
  end

  // Control and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
    end
  end

  // Branch-target LUT: synchronous write in any state.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this array is only 16 flop words and must read back 0 after reset, so it is reset explicitly.
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) lut[i] <= '0;
    end else if (lut_we) begin
      lut[lut_waddr] <= lut_wdata;
    end
  end

`ifdef FETCH_PERF_EN
  // Retired-instruction counter: every non-stalled RUN cycle, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= '0;
    end else if (start_ok) begin
      retired_cnt <= '0;
    end else if (state == S_RUN && !stall && retired_cnt != 16'hFFFF) begin
      retired_cnt <= retired_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_roe_fetch.sv
// tb_roe_fetch -- self-checking bench for roe_fetch.
// A behavioural model (program running flag, PC, done/err, LUT copy) is
// stepped once per clock from the program in the bench's instruction memory;
// every DUT output is compared on the falling edge.
module tb_roe_fetch;

  localparam int         PC_W  = 10;
  localparam int         DEPTH = 1024;
  localparam logic [8:0] HALT  = 9'h1FF;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [PC_W-1:0] start_pc = '0;
  logic            stall = 1'b0;
  logic            branch_taken = 1'b0;
  logic            lut_we = 1'b0;
  logic [3:0]      lut_waddr = '0;
  logic [PC_W-1:0] lut_wdata = '0;
  logic [PC_W-1:0] imem_addr;
  logic [8:0]      imem_data;
  logic [8:0]      instr;
  logic            instr_valid;
  logic [PC_W-1:0] pc;
  logic            done;
  logic            err;
`ifdef FETCH_PERF_EN
  logic [15:0]     retired_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [8:0] mem [DEPTH];

  // Reference model state.
  bit              m_rst;
  bit              m_run;
  bit              m_done;
  bit              m_err;
  logic [PC_W-1:0] m_pc;
  logic [PC_W-1:0] m_lut [16];
  int              m_cnt;

  roe_fetch #(.PC_W(PC_W), .IMEM_DEPTH(DEPTH), .HALT_INSTR(HALT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .start_pc     (start_pc),
    .stall        (stall),
    .branch_taken (branch_taken),
    .lut_we       (lut_we),
    .lut_waddr    (lut_waddr),
    .lut_wdata    (lut_wdata),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .done         (done),
    .err          (err)
`ifdef FETCH_PERF_EN
    ,
    .retired_cnt  (retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory, one-cycle read latency.
  always @(posedge clk) imem_data <= mem[imem_addr];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, observed running, required finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_rst  = 1'b1;
    m_run  = 1'b0;
    m_done = 1'b0;
    m_err  = 1'b0;
    m_pc   = '0;
    m_cnt  = 0;
    for (int i = 0; i < 16; i++) m_lut[i] = '0;
  endtask

  // Address the fetch stage should present this cycle.
  function automatic logic [PC_W-1:0] exp_addr();
    if (m_rst) return '0;
    if (!m_run) return (start || !m_done) ? start_pc : m_pc;
    if (stall || mem[m_pc] == HALT) return m_pc;
    if (branch_taken) return m_lut[mem[m_pc][3:0]];
    if (int'(m_pc) == DEPTH - 1) return m_pc;
    return PC_W'(int'(m_pc) + 1);
  endfunction

  // One clock of program execution, from the inputs held during the cycle.
  task automatic model_update();
    if (!m_run) begin
      if (start) begin
        m_run  = 1'b1;
        m_pc   = start_pc;
        m_done = 1'b0;
        m_err  = 1'b0;
        m_cnt  = 0;
      end
    end else if (!stall) begin
      if (m_cnt < 65535) m_cnt++;
      if (mem[m_pc] == HALT) begin
        m_run  = 1'b0;
        m_done = 1'b1;
      end else if (branch_taken) begin
        m_pc = m_lut[mem[m_pc][3:0]];
      end else if (int'(m_pc) == DEPTH - 1) begin
        m_run  = 1'b0;
        m_done = 1'b1;
        m_err  = 1'b1;
      end else begin
        m_pc = PC_W'(int'(m_pc) + 1);
      end
    end
    if (lut_we) m_lut[lut_waddr] = lut_wdata;
  endtask

  task automatic compare();
    check("instr_valid", {31'd0, instr_valid}, {31'd0, m_run});
    check("instr", {23'd0, instr}, m_run ? {23'd0, mem[m_pc]} : 32'd0);
    check("pc", {22'd0, pc}, {22'd0, m_pc});
    check("imem_addr", {22'd0, imem_addr}, {22'd0, exp_addr()});
    check("done", {31'd0, done}, {31'd0, m_done});
    check("err", {31'd0, err}, {31'd0, m_err});
`ifdef FETCH_PERF_EN
    check("retired_cnt", {16'd0, retired_cnt}, m_cnt);
`endif
  endtask

  // Drive one cycle from a falling edge: set inputs, compare, clock, advance model.
  task automatic tick(input bit s, input bit st, input bit bt);
    start        = s;
    stall        = st;
    branch_taken = bt;
    #1 compare();
    @(posedge clk);
    model_update();
    @(negedge clk);
    start        = 1'b0;
    stall        = 1'b0;
    branch_taken = 1'b0;
    lut_we       = 1'b0;
  endtask

  task automatic run_until_done(input int limit);
    for (int i = 0; i < limit && m_run; i++) tick(1'b0, 1'b0, 1'b0);
    check("run_ends_done", {31'd0, done}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 9'h000;
    mem[10'h012] = 9'h035;
    mem[10'h014] = HALT;
    mem[10'h042] = HALT;
    mem[10'h060] = HALT;

    // Reset state.
    model_reset();
    #1 compare();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_rst = 1'b0;

    // LUT[5] = 0x040 written while idle.
    lut_we = 1'b1; lut_waddr = 4'd5; lut_wdata = 10'h040;
    tick(1'b0, 1'b0, 1'b0);

    // Sequential run 0x010..0x014, halt at 0x014.
    start_pc = 10'h010;
    tick(1'b1, 1'b0, 1'b0);
    run_until_done(20);
    check("seq_halt_pc", {22'd0, pc}, 32'h014);
    check("seq_err", {31'd0, err}, 32'd0);
    tick(1'b0, 1'b0, 1'b0);

    // Stall at 0x011 with an ignored branch pulse, then branch at 0x012 -> 0x040.
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b0);
    check("stall_pc", {22'd0, pc}, 32'h011);
    tick(1'b0, 1'b0, 1'b0);
    check("after_stall_pc", {22'd0, pc}, 32'h012);
    tick(1'b0, 1'b0, 1'b1);
    check("branch_target", {22'd0, pc}, 32'h040);
    check("branch_no_bubble", {31'd0, instr_valid}, 32'd1);
    run_until_done(20);

    // Overflow: run off the last word with no halt.
    start_pc = 10'h3FE;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check("ovf_done", {31'd0, done}, 32'd1);
    check("ovf_err", {31'd0, err}, 32'd1);
    check("ovf_no_wrap", {22'd0, imem_addr}, 32'h3FF);
    tick(1'b0, 1'b0, 1'b0);

    // Restart from DONE; LUT write to entry 5 in the same cycle as a branch via entry 5.
    start_pc = 10'h010;
    tick(1'b1, 1'b0, 1'b0);
    check("restart_clears_err", {31'd0, err}, 32'd0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    lut_we = 1'b1; lut_waddr = 4'd5; lut_wdata = 10'h060;
    tick(1'b1, 1'b0, 1'b1);
    check("hazard_old_target", {22'd0, pc}, 32'h040);
    run_until_done(20);

    // The new target is used on the next run.
    start_pc = 10'h012;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    check("new_target", {22'd0, pc}, 32'h060);
    run_until_done(20);

    // Asynchronous reset mid-run, between clock edges.
    start_pc = 10'h010;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1 compare();
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_rst = 1'b0;
    // Cleared LUT: branch via entry 5 now goes to 0.
    start_pc = 10'h012;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    check("lut_cleared", {22'd0, pc}, 32'h000);
    run_until_done(40);

    // Randomized phase: random program, stalls, branches, LUT writes, stray starts.
    for (int i = 0; i < DEPTH; i++)
      mem[i] = ($urandom_range(0, 23) == 0) ? HALT : 9'($urandom_range(0, 510));
    for (int n = 0; n < 4000; n++) begin
      bit s, st, bt;
      if (m_run) s = ($urandom_range(0, 19) == 0);
      else       s = ($urandom_range(0, 3) == 0);
      if (s && !m_run) start_pc = 10'($urandom_range(0, DEPTH - 1));
      st = ($urandom_range(0, 3) == 0);
      bt = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 9) == 0) begin
        lut_we    = 1'b1;
        lut_waddr = 4'($urandom_range(0, 15));
        lut_wdata = 10'($urandom_range(0, DEPTH - 1));
      end
      tick(s, st, bt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
